// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush scheduler for the 5-stage MIPS pipeline. Produces the
// write enables for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches,
// the ID/EX bubble select and the IF/ID squash, and tracks the busy window
// of the multi-cycle mul/div unit for HI/LO conflict detection.
//
// Per-cycle priority: freeze > load-use > hilo > taken branch > run.
//
// Parameters
//   REG_W       register-specifier width
//   MULDIV_LAT  mul/div busy cycles after the start pulse (>= 1)
//   CNT_W       performance counter width (only with HAZARD_PERF_CNT_EN)
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   id_rs, id_rt             source registers of the ID instruction
//   id_uses_rs, id_uses_rt   ID instruction really reads rs / rt
//   id_is_hilo               ID instruction touches HI/LO
//   ex_mem_read, ex_rt       load in EX and its destination register
//   ex_muldiv_start          one-cycle mul/div issue pulse from EX
//   mem_stall_req            data memory not ready (freezes everything)
//   id_branch_taken          branch/jump in ID resolved taken
//   pc_we .. memwb_we        latch write enables
//   idex_bubble              load a NOP into ID/EX
//   ifid_flush               clear IF/ID at the next edge
//   muldiv_busy              mul/div busy counter non-zero
//   stall_cause              registered: 0 none, 1 load-use, 2 hilo, 3 freeze
//
// Optional feature (macro HAZARD_PERF_CNT_EN): adds stall_cycles,
// bubble_count and flush_count outputs, CNT_W bits each, wrapping.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_hilo,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_muldiv_start,
    input  logic             mem_stall_req,
    input  logic             id_branch_taken,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             muldiv_busy,
    output logic [1:0]       stall_cause
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count
`endif
);

    // Elaboration-time sanity checks on the configuration.
    generate
        if (MULDIV_LAT < 1) begin : g_bad_lat
            $error("pipe_hazard_ctrl: MULDIV_LAT must be at least 1");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("pipe_hazard_ctrl: CNT_W must be at least 1");
        end
    endgenerate

    localparam int unsigned MD_W = $clog2(MULDIV_LAT + 1);
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_LAT);
    localparam logic [MD_W-1:0] MD_ONE  = MD_W'(1);

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_LOAD   = 2'd1,
        CAUSE_HILO   = 2'd2,
        CAUSE_FREEZE = 2'd3
    } cause_t;

    logic [MD_W-1:0] r_md_cnt;
    cause_t          r_cause;

    logic   w_busy;
    logic   w_load_use;
    logic   w_hilo_hz;
    logic   w_freeze;
    logic   w_front_we;   // PC and IF/ID
    logic   w_back_we;    // ID/EX, EX/MEM, MEM/WB
    logic   w_bubble;
    logic   w_flush;
    cause_t w_cause;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_busy   = (r_md_cnt != '0);
    assign w_freeze = mem_stall_req;

    // r0 is hard-wired to zero, so a load targeting it never creates a
    // real dependency.
    assign w_load_use = ex_mem_read & (ex_rt != '0) &
                        ((id_uses_rs & (id_rs == ex_rt)) |
                         (id_uses_rt & (id_rt == ex_rt)));

    assign w_hilo_hz = id_is_hilo & w_busy;

    // ------------------------------------------------------------------
    // Control decode (priority resolution)
    // ------------------------------------------------------------------
    always_comb begin
        w_front_we = 1'b0;
        w_back_we  = 1'b0;
        w_bubble   = 1'b0;
        w_flush    = 1'b0;
        w_cause    = CAUSE_NONE;

        if (!rst) begin
            // Held in reset: everything stays deasserted.
        end else if (w_freeze) begin
            // Whole pipeline holds; a taken branch stays in ID and is
            // re-evaluated once the freeze lifts.
            w_cause = CAUSE_FREEZE;
        end else if (w_load_use || w_hilo_hz) begin
            // Hold PC and IF/ID, inject a NOP into ID/EX, let the back end
            // drain.
            w_back_we = 1'b1;
            w_bubble  = 1'b1;
            w_cause   = w_load_use ? CAUSE_LOAD : CAUSE_HILO;
        end else begin
            w_front_we = 1'b1;
            w_back_we  = 1'b1;
            w_flush    = id_branch_taken;
        end
    end

    assign pc_we       = w_front_we;
    assign ifid_we     = w_front_we;
    assign idex_we     = w_back_we;
    assign exmem_we    = w_back_we;
    assign memwb_we    = w_back_we;
    assign idex_bubble = w_bubble;
    assign ifid_flush  = w_flush;
    assign muldiv_busy = w_busy;
    assign stall_cause = r_cause;

    // ------------------------------------------------------------------
    // Mul/div busy counter: runs independently of freeze; a new start
    // reloads rather than extends.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_md_cnt <= '0;
        end else if (ex_muldiv_start) begin
            r_md_cnt <= MD_LOAD;
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - MD_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Registered stall cause
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cause <= CAUSE_NONE;
        end else begin
            r_cause <= w_cause;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (wrap naturally at 2^CNT_W)
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] PC_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_bubble_count;
    logic [CNT_W-1:0] r_flush_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_bubble_count <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_freeze) begin
                r_stall_cycles <= r_stall_cycles + PC_ONE;
            end
            if (w_bubble) begin
                r_bubble_count <= r_bubble_count + PC_ONE;
            end
            if (w_flush) begin
                r_flush_count <= r_flush_count + PC_ONE;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign bubble_count = r_bubble_count;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed scenarios with literal expectations, followed by randomized
// traffic. A behavioural model (cycle class + remaining busy cycles) predicts
// every output; one compare process checks the DUT on each falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int unsigned LAT   = 4;
    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             id_uses_rs, id_uses_rt, id_is_hilo;
    logic             ex_mem_read, ex_muldiv_start, mem_stall_req, id_branch_taken;
    logic             pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic             idex_bubble, ifid_flush, muldiv_busy;
    logic [1:0]       stall_cause;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, bubble_count, flush_count;
`endif

    pipe_hazard_ctrl #(
        .REG_W      (REG_W),
        .MULDIV_LAT (LAT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_is_hilo      (id_is_hilo),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_muldiv_start (ex_muldiv_start),
        .mem_stall_req   (mem_stall_req),
        .id_branch_taken (id_branch_taken),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .idex_we         (idex_we),
        .exmem_we        (exmem_we),
        .memwb_we        (memwb_we),
        .idex_bubble     (idex_bubble),
        .ifid_flush      (ifid_flush),
        .muldiv_busy     (muldiv_busy),
        .stall_cause     (stall_cause)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .bubble_count    (bubble_count),
        .flush_count     (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    //   class: 0 run, 1 load-use, 2 hilo, 3 freeze, 4 taken branch
    //   m_left: mul/div cycles still busy
    // ------------------------------------------------------------------
    int               m_left  = 0;
    int               m_cause = 0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_bub   = '0;
    logic [CNT_W-1:0] m_fl    = '0;

    function automatic int cycle_class();
        bit dep;
        if (mem_stall_req) return 3;
        dep = (id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt);
        if (ex_mem_read && ex_rt != 0 && dep) return 1;
        if (id_is_hilo && m_left > 0) return 2;
        if (id_branch_taken) return 4;
        return 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        int c;
        if (!rst) begin
            m_left  = 0;
            m_cause = 0;
            m_stall = '0;
            m_bub   = '0;
            m_fl    = '0;
        end else begin
            c = cycle_class();
            m_cause = (c == 4) ? 0 : c;
            if (c == 3) m_stall = m_stall + 1'b1;
            if (c == 1 || c == 2) m_bub = m_bub + 1'b1;
            if (c == 4) m_fl = m_fl + 1'b1;
            if (ex_muldiv_start) m_left = LAT;
            else if (m_left > 0) m_left = m_left - 1;
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        int  c;
        bit  front, back;
        c     = rst ? cycle_class() : -1;
        front = rst && (c == 0 || c == 4);
        back  = rst && (c != 3);
        chk("pc_we",       pc_we,       front);
        chk("ifid_we",     ifid_we,     front);
        chk("idex_we",     idex_we,     back);
        chk("exmem_we",    exmem_we,    back);
        chk("memwb_we",    memwb_we,    back);
        chk("idex_bubble", idex_bubble, rst && (c == 1 || c == 2));
        chk("ifid_flush",  ifid_flush,  rst && (c == 4));
        chk("muldiv_busy", muldiv_busy, m_left > 0);
        chk("stall_cause", stall_cause, m_cause);
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, m_stall);
        chk("bubble_count", bubble_count, m_bub);
        chk("flush_count",  flush_count,  m_fl);
`endif
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_is_hilo = 0;
        ex_mem_read = 0; ex_muldiv_start = 0; mem_stall_req = 0; id_branch_taken = 0;
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        #1 rst = 1'b0;
        repeat (3) cyc();

        // Reset release, idle inputs: free-running pipeline.
        rst = 1'b1;
        #2;
        chk("lit_idle_pc_we", pc_we, 1);
        chk("lit_idle_memwb_we", memwb_we, 1);
        chk("lit_idle_bubble", idex_bubble, 0);
        chk("lit_idle_flush", ifid_flush, 0);
        chk("lit_idle_cause", stall_cause, 0);
        chk("lit_idle_busy", muldiv_busy, 0);

        // Load-use on rs.
        cyc();
        ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
        #2;
        chk("lit_lu_pc_we", pc_we, 0);
        chk("lit_lu_ifid_we", ifid_we, 0);
        chk("lit_lu_bubble", idex_bubble, 1);
        chk("lit_lu_idex_we", idex_we, 1);
        cyc();
        clear_inputs();
        #2;
        chk("lit_lu_cause", stall_cause, 1);
        chk("lit_lu_resume", pc_we, 1);

        // Load to r0 never stalls.
        cyc();
        ex_mem_read = 1; ex_rt = '0; id_rs = '0; id_uses_rs = 1;
        #2;
        chk("lit_r0_pc_we", pc_we, 1);
        chk("lit_r0_bubble", idex_bubble, 0);

        // Mul/div start with HI/LO reader held in ID.
        cyc();
        clear_inputs();
        ex_muldiv_start = 1; id_is_hilo = 1;
        #2;
        chk("lit_md_busy0", muldiv_busy, 0);
        chk("lit_md_pc0", pc_we, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            ex_muldiv_start = 0;
            #2;
            chk("lit_md_busy", muldiv_busy, 1);
            chk("lit_md_bubble", idex_bubble, 1);
            chk("lit_md_pc_we", pc_we, 0);
        end
        cyc();
        #2;
        chk("lit_md_done_busy", muldiv_busy, 0);
        chk("lit_md_done_bubble", idex_bubble, 0);
        chk("lit_md_done_pc", pc_we, 1);
        chk("lit_md_cause", stall_cause, 2);

        // Freeze over a taken branch for 3 cycles.
        cyc();
        clear_inputs();
        mem_stall_req = 1; id_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) cyc();
            #2;
            chk("lit_fz_pc_we", pc_we, 0);
            chk("lit_fz_memwb_we", memwb_we, 0);
            chk("lit_fz_flush", ifid_flush, 0);
            #1;
        end
        cyc();
        mem_stall_req = 0;
        #2;
        chk("lit_fz_end_flush", ifid_flush, 1);
        chk("lit_fz_end_cause", stall_cause, 3);
        chk("lit_fz_end_pc", pc_we, 1);

        // Load-use beats a taken branch.
        cyc();
        clear_inputs();
        ex_mem_read = 1; ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1; id_branch_taken = 1;
        #2;
        chk("lit_lub_flush", ifid_flush, 0);
        chk("lit_lub_bubble", idex_bubble, 1);
        cyc();
        ex_mem_read = 0;
        #2;
        chk("lit_lub_flush_next", ifid_flush, 1);
        chk("lit_lub_cause", stall_cause, 1);

        // Reset in the middle of a busy window (counter at 2).
        cyc();
        clear_inputs();
        ex_muldiv_start = 1;
        cyc();                 // counter 4
        ex_muldiv_start = 0;
        cyc();                 // counter 3
        cyc();                 // counter 2
        chk("lit_mid_busy_pre", muldiv_busy, 1);
        rst = 1'b0;
        #1;
        chk("lit_mid_busy", muldiv_busy, 0);
        chk("lit_mid_pc_we", pc_we, 0);
        chk("lit_mid_memwb_we", memwb_we, 0);
        chk("lit_mid_cause", stall_cause, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("lit_mid_stall_cnt", stall_cycles, 0);
        chk("lit_mid_bubble_cnt", bubble_count, 0);
        chk("lit_mid_flush_cnt", flush_count, 0);
`endif
        cyc();
        rst = 1'b1;

        // Randomized traffic; small register range to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst             = ($urandom_range(0, 149) != 0);
            id_rs           = REG_W'($urandom_range(0, 3));
            id_rt           = REG_W'($urandom_range(0, 3));
            ex_rt           = REG_W'($urandom_range(0, 3));
            id_uses_rs      = $urandom_range(0, 1) == 1;
            id_uses_rt      = $urandom_range(0, 1) == 1;
            id_is_hilo      = $urandom_range(0, 2) == 0;
            ex_mem_read     = $urandom_range(0, 2) == 0;
            ex_muldiv_start = $urandom_range(0, 9) == 0;
            mem_stall_req   = $urandom_range(0, 4) == 0;
            id_branch_taken = $urandom_range(0, 3) == 0;
        end

        cyc();
        clear_inputs();
        rst = 1'b1;
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
